// File: rtl/byte_packer_pkg.sv
// Shared types and defaults for the byte_packer streaming assembler.
// Optional build macro BYTE_PACKER_BSWAP_EN (see byte_packer_lane_mux).
package byte_packer_pkg;

  localparam int unsigned BYTE_W_DEF         = 8;
  localparam int unsigned BYTES_PER_WORD_DEF = 4;
  localparam int unsigned CNT_W_DEF          = 16;

  typedef logic [BYTES_PER_WORD_DEF*BYTE_W_DEF-1:0] word_t;
  typedef logic [BYTES_PER_WORD_DEF-1:0]            be_t;
  typedef logic [$clog2(BYTES_PER_WORD_DEF)-1:0]    idx_t;

  // FILL: collecting bytes; HOLD: a finished word is presented downstream.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/byte_packer_lane_mux.sv
// Combinational lane steering: merges the incoming byte into the assembly
// word at the lane selected by the byte index and sets its enable bit.
// BYTE_PACKER_BSWAP_EN defined: byte idx goes to lane N-1-idx (MSB first).
// BYTE_PACKER_BSWAP_EN undefined: byte idx goes to lane idx (LSB first).
module byte_packer_lane_mux
  import byte_packer_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int unsigned BYTE_W         = BYTE_W_DEF
) (
  input  logic [BYTES_PER_WORD*BYTE_W-1:0]     i_asm_word,
  input  logic [BYTES_PER_WORD-1:0]            i_asm_mask,
  input  logic [$clog2(BYTES_PER_WORD)-1:0]    i_idx,
  input  logic [BYTE_W-1:0]                    i_data,
  output logic [BYTES_PER_WORD*BYTE_W-1:0]     o_word,
  output logic [BYTES_PER_WORD-1:0]            o_mask
);

  localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] w_lane;

`ifdef BYTE_PACKER_BSWAP_EN
  assign w_lane = IDX_W'(BYTES_PER_WORD - 1) - i_idx;
`else
  assign w_lane = i_idx;
`endif

  // Overwrite the selected lane with the new byte and mark it enabled.
  always_comb begin
    o_word = i_asm_word;
    o_mask = i_asm_mask;
    for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
      if (w_lane == IDX_W'(k)) begin
        o_word[k*BYTE_W +: BYTE_W] = i_data;
        o_mask[k]                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/byte_packer.sv
// Byte-to-word assembler: one byte per cycle in, one registered word out,
// with byte-enable mask for short final words and a running word count.
// Optional build macro BYTE_PACKER_BSWAP_EN selects MSB-first lane order.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int unsigned BYTE_W         = BYTE_W_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BYTE_W-1:0]                 in_data,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BYTES_PER_WORD*BYTE_W-1:0]  out_data,
  output logic [BYTES_PER_WORD-1:0]         out_be,
  output logic                              out_last,
  output logic [CNT_W-1:0]                  out_words
);

  localparam int unsigned WORD_W = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned IDX_W  = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [WORD_W-1:0]     r_asm_word;
  logic [BYTES_PER_WORD-1:0] r_asm_mask;
  logic [WORD_W-1:0]     r_out_data;
  logic [BYTES_PER_WORD-1:0] r_out_be;
  logic                  r_out_last;
  logic [CNT_W-1:0]      r_out_words;

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_complete;
  logic [WORD_W-1:0]     w_mux_word;
  logic [BYTES_PER_WORD-1:0] w_mux_mask;

  assign out_valid  = (r_state == HOLD);
  assign in_ready   = (r_state == FILL) || out_ready;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_complete = w_in_fire && ((r_idx == LAST_IDX) || in_last);

  assign out_data  = r_out_data;
  assign out_be    = r_out_be;
  assign out_last  = r_out_last;
  assign out_words = r_out_words;

  byte_packer_lane_mux #(
    .BYTES_PER_WORD (BYTES_PER_WORD),
    .BYTE_W         (BYTE_W)
  ) u_lane_mux (
    .i_asm_word (r_asm_word),
    .i_asm_mask (r_asm_mask),
    .i_idx      (r_idx),
    .i_data     (in_data),
    .o_word     (w_mux_word),
    .o_mask     (w_mux_mask)
  );

  // Next state: a completion always (re)fills the output; a bare handshake empties it.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FILL: if (w_complete) w_state_nxt = HOLD;
      HOLD: if (w_out_fire && !w_complete) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  // Byte index and assembly buffer; cleared whenever a word completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_asm_word <= '0;
      r_asm_mask <= '0;
    end else if (w_complete) begin
      r_idx      <= '0;
      r_asm_word <= '0;
      r_asm_mask <= '0;
    end else if (w_in_fire) begin
      r_idx      <= r_idx + IDX_W'(1);
      r_asm_word <= w_mux_word;
      r_asm_mask <= w_mux_mask;
    end
  end

  // Output register loads only on completion, so it stays stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_be   <= '0;
      r_out_last <= 1'b0;
    end else if (w_complete) begin
      r_out_data <= w_mux_word;
      r_out_be   <= w_mux_mask;
      r_out_last <= in_last;
    end
  end

  // Emitted-word counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_out_words <= '0;
    else if (w_out_fire) r_out_words <= r_out_words + CNT_W'(1);
  end

endmodule

// File: tb/tb_byte_packer.sv
// Self-checking bench for byte_packer: directed scenarios plus random traffic
// scored against a packet-level reference model (byte lists -> words).
// Honours BYTE_PACKER_BSWAP_EN for expected lane order.
module tb_byte_packer;
  import byte_packer_pkg::*;

  localparam int unsigned N  = BYTES_PER_WORD_DEF;
  localparam int unsigned BW = BYTE_W_DEF;
  localparam int unsigned CW = CNT_W_DEF;

`ifdef BYTE_PACKER_BSWAP_EN
  localparam bit    BSWAP     = 1'b1;
  localparam word_t EXP_DBEF  = 32'hefbeadde;
  localparam word_t EXP_BBAA  = 32'haabb0000;
  localparam be_t   EXP_BE2   = 4'hC;
  localparam be_t   EXP_BE1   = 4'h8;
  localparam word_t EXP_H1    = 32'h00010203;
  localparam word_t EXP_RST   = 32'h11223344;
`else
  localparam bit    BSWAP     = 1'b0;
  localparam word_t EXP_DBEF  = 32'hdeadbeef;
  localparam word_t EXP_BBAA  = 32'h0000bbaa;
  localparam be_t   EXP_BE2   = 4'h3;
  localparam be_t   EXP_BE1   = 4'h1;
  localparam word_t EXP_H1    = 32'h03020100;
  localparam word_t EXP_RST   = 32'h44332211;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  word_t         out_data;
  be_t           out_be;
  logic          out_last;
  logic [CW-1:0] out_words;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state: bytes of the packet-in-progress and pending words.
  logic [BW-1:0] pkt_bytes[$];
  word_t         q_word[$];
  be_t           q_be[$];
  logic          q_last[$];
  logic [CW-1:0] m_cnt = '0;

  always #5 clk = ~clk;

  byte_packer #(
    .BYTES_PER_WORD (N),
    .BYTE_W         (BW),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_be    (out_be),
    .out_last  (out_last),
    .out_words (out_words)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Turn the collected packet bytes into one expected word.
  function automatic void emit_word(input logic last);
    word_t w = '0;
    be_t   b = '0;
    for (int i = 0; i < pkt_bytes.size(); i++) begin
      int lane = BSWAP ? (N - 1 - i) : i;
      w[lane*BW +: BW] = pkt_bytes[i];
      b[lane] = 1'b1;
    end
    q_word.push_back(w);
    q_be.push_back(b);
    q_last.push_back(last);
    pkt_bytes.delete();
  endfunction

  // Scoreboard: compare visible output against the model, then apply this cycle's handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      pkt_bytes.delete();
      q_word.delete();
      q_be.delete();
      q_last.delete();
      m_cnt = '0;
    end else begin
      check("out_valid", out_valid, q_word.size() != 0);
      check("in_ready", in_ready, !out_valid || out_ready);
      check("out_words", out_words, m_cnt);
      if (out_valid && q_word.size() != 0) begin
        check("out_data", out_data, q_word[0]);
        check("out_be", out_be, q_be[0]);
        check("out_last", out_last, q_last[0]);
      end
      if (out_valid && out_ready && q_word.size() != 0) begin
        void'(q_word.pop_front());
        void'(q_be.pop_front());
        void'(q_last.pop_front());
        m_cnt = m_cnt + 1'b1;
      end
      if (in_valid && in_ready) begin
        pkt_bytes.push_back(in_data);
        if (pkt_bytes.size() == N || in_last) emit_word(in_last);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst_out_data", out_data, '0);
    check("rst_out_be", out_be, '0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_words", out_words, '0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  // Present one byte until accepted (bounded), then leave garbage on the bus.
  task automatic send(input logic [BW-1:0] d, input logic l);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    check("accept_wait", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = BW'($urandom);
    in_last  = 1'($urandom);
  endtask

  initial begin
    do_reset();

    // Full word, back-to-back.
    send(8'hef, 1'b0); send(8'hbe, 1'b0); send(8'had, 1'b0); send(8'hde, 1'b0);
    check("w1_valid", out_valid, 1'b1);
    check("w1_data", out_data, EXP_DBEF);
    check("w1_be", out_be, 4'hF);
    check("w1_last", out_last, 1'b0);
    @(posedge clk); #1;
    check("w1_count", out_words, 16'd1);

    // Short packet flushed by in_last.
    send(8'haa, 1'b0); send(8'hbb, 1'b1);
    check("p2_data", out_data, EXP_BBAA);
    check("p2_be", out_be, EXP_BE2);
    check("p2_last", out_last, 1'b1);

    // in_last on the final lane, then a single-byte packet.
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
    check("lastlane_be", out_be, 4'hF);
    check("lastlane_last", out_last, 1'b1);
    send(8'h5a, 1'b1);
    check("single_be", out_be, EXP_BE1);
    check("single_last", out_last, 1'b1);

    // Backpressure: 8 bytes while the first word is held.
    do_reset();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(8'(i), 1'b0);
      end
      begin
        repeat (8) @(posedge clk);
        #2;
        check("hold_in_ready", in_ready, 1'b0);
        check("hold_data", out_data, EXP_H1);
        repeat (3) @(posedge clk);
        #2;
        check("hold_stable", out_data, EXP_H1);
        check("hold_be", out_be, 4'hF);
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("hold_count", out_words, 16'd2);
    check("hold_drained", out_valid, 1'b0);

    // Continuous 12-byte stream.
    do_reset();
    for (int i = 0; i < 12; i++) send(8'(8'h10 + i), 1'b0);
    @(posedge clk); #1;
    check("stream_count", out_words, 16'd3);

    // Reset mid-word, and reset while a word is held.
    do_reset();
    send(8'h99, 1'b0); send(8'h98, 1'b0);
    do_reset();
    out_ready = 1'b0;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    do_reset();
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    check("rst_word", out_data, EXP_RST);
    @(posedge clk); #1;
    check("rst_count", out_words, 16'd1);

    // Randomized traffic with random backpressure.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = BW'($urandom);
      in_last   = ($urandom_range(5) == 0);
      out_ready = ($urandom_range(2) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Counter wrap: single-byte packets, one word per cycle.
    do_reset();
    for (int i = 0; i < 65535; i++) send(8'(i), 1'b1);
    @(posedge clk); #1;
    check("wrap_max", out_words, 16'hFFFF);
    send(8'h77, 1'b1);
    @(posedge clk); #1;
    check("wrap_zero", out_words, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
